// File: rtl/dm_arb_pkg.sv
// Shared types and width defaults for the two-port data-memory arbiter.
package dm_arb_pkg;

  typedef enum logic {IDLE, RESP} state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam int ADDR_W_DEFAULT = 32;
  localparam int DATA_W_DEFAULT = 32;

endpackage

// File: rtl/dm_arb_grant.sv
// Combinational 2-way grant. DM_ARB_ROUND_ROBIN_EN selects round-robin on contention;
// otherwise requester 0 has fixed priority and no last-grant history is used.
module dm_arb_grant
  import dm_arb_pkg::*;
(
`ifdef DM_ARB_ROUND_ROBIN_EN
  input  logic       last_grant,
`endif
  input  logic [1:0] valid,
  output logic       grant_any,
  output logic       grant_id
);

  assign grant_any = |valid;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    grant_id = REQ0;
`ifdef DM_ARB_ROUND_ROBIN_EN
    if (valid == 2'b11) grant_id = ~last_grant;
    else if (valid == 2'b10) grant_id = REQ1;
`else
    if (valid == 2'b10) grant_id = REQ1;
`endif
  end

endmodule

// File: rtl/dm_arbiter.sv
// Shares the single-port data memory between two requesters; 1-cycle read responses are
// routed back to the issuing requester. DM_ARB_ROUND_ROBIN_EN enables round-robin grant.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_valid,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ready,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_valid,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ready,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              dm_read,
  output logic              dm_write,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata
);

  logic              grant_any;
  logic              grant_id;
  logic              accept;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              resp_active;
  state_t            state_q, state_d;
  logic              rsp_owner_q, rsp_owner_d;

`ifdef DM_ARB_ROUND_ROBIN_EN
  logic              last_grant_q;
`endif

  dm_arb_grant u_grant (
`ifdef DM_ARB_ROUND_ROBIN_EN
    .last_grant (last_grant_q),
`endif
    .valid      ({r1_valid, r0_valid}),
    .grant_any  (grant_any),
    .grant_id   (grant_id)
  );

  assign sel_we    = (grant_id == REQ1) ? r1_we    : r0_we;
  assign sel_addr  = (grant_id == REQ1) ? r1_addr  : r0_addr;
  assign sel_wdata = (grant_id == REQ1) ? r1_wdata : r0_wdata;

  // Reset masks every handshake and strobe, even though grant itself is combinational.
  assign accept   = grant_any & ~reset;
  assign r0_ready = accept & (grant_id == REQ0);
  assign r1_ready = accept & (grant_id == REQ1);
  assign dm_read  = accept & ~sel_we;
  assign dm_write = accept &  sel_we;
  assign dm_addr  = accept ? sel_addr  : '0;
  assign dm_wdata = accept ? sel_wdata : '0;

  assign resp_active = (state_q == RESP) & ~reset;
  assign r0_rvalid   = resp_active & (rsp_owner_q == REQ0);
  assign r1_rvalid   = resp_active & (rsp_owner_q == REQ1);
  assign r0_rdata    = reset ? '0 : dm_rdata;
  assign r1_rdata    = reset ? '0 : dm_rdata;

  // A read accepted while a response is in flight simply re-arms RESP for its own owner.
  always_comb begin
    state_d     = IDLE;
    rsp_owner_d = rsp_owner_q;
    if (dm_read) begin
      state_d     = RESP;
      rsp_owner_d = grant_id;
    end
  end

  // NOTE: registered state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rsp_owner_q <= REQ0;
    end else begin
      state_q     <= state_d;
      rsp_owner_q <= rsp_owner_d;
    end
  end

`ifdef DM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (reset)       last_grant_q <= REQ1;
    else if (accept) last_grant_q <= grant_id;
  end
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter paired with a small seeded data-memory model.
// Expectations cover both the fixed-priority and DM_ARB_ROUND_ROBIN_EN builds.
module tb_dm_arbiter;

`ifdef DM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_valid, r0_we, r1_valid, r1_we;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic        r0_ready, r0_rvalid, r1_ready, r1_rvalid;
  logic [31:0] r0_rdata, r1_rdata;
  logic        dm_read, dm_write;
  logic [31:0] dm_addr, dm_wdata;
  logic [31:0] dm_rdata = '0;
  logic [31:0] mem [0:63];

  int n_tests = 0;
  int n_fail  = 0;
  int rd_cnt  = 0;
  int rv_cnt  = 0;
  bit done    = 1'b0;

  always #5 clk = ~clk;

  dm_arbiter dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ready(r0_ready), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_valid(r1_valid), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ready(r1_ready), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata)
  );

  // Memory image is reloaded on reset: word i holds A000_0000 + i.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 + i;
    end else begin
      if (dm_write) mem[dm_addr[7:2]] <= dm_wdata;
      if (dm_read)  dm_rdata <= mem[dm_addr[7:2]];
    end
  end

  function automatic logic [31:0] seed(input int i);
    return 32'hA000_0000 + i;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic we0, input logic [31:0] a0,
                       input logic [31:0] d0, input logic v1, input logic we1,
                       input logic [31:0] a1, input logic [31:0] d1);
    r0_valid = v0; r0_we = we0; r0_addr = a0; r0_wdata = d0;
    r1_valid = v1; r1_we = we1; r1_addr = a1; r1_wdata = d1;
  endtask

  // Per-cycle invariants and read/response accounting, sampled mid-low-phase.
  always @(negedge clk) begin
    #2;
    if (!done) begin
      check("excl_strobe", {31'd0, dm_read & dm_write}, 32'd0);
      check("excl_ready", {31'd0, r0_ready & r1_ready}, 32'd0);
      rd_cnt += int'(r0_valid & r0_ready & ~r0_we) + int'(r1_valid & r1_ready & ~r1_we);
      rv_cnt += int'(r0_rvalid) + int'(r1_rvalid);
    end
  end

  initial begin
    bit g0, p1;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    // Requests during reset are masked.
    drive(1, 0, 32'h10, 0, 1, 1, 32'h14, 32'h55);
    #1;
    check("rst_r0_ready", r0_ready, 0);
    check("rst_r1_ready", r1_ready, 0);
    check("rst_dm_read", dm_read, 0);
    check("rst_dm_write", dm_write, 0);
    check("rst_dm_addr", dm_addr, 0);
    check("rst_rvalid", {r1_rvalid, r0_rvalid}, 0);
    @(negedge clk);
    reset = 1'b0;

    // 1. Single requester write then read-back.
    drive(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0);
    #1;
    check("t1_wr_ready", r0_ready, 1);
    check("t1_wr_strobe", {dm_read, dm_write}, 2'b01);
    check("t1_wr_addr", dm_addr, 32'h10);
    check("t1_wr_data", dm_wdata, 32'hDEADBEEF);
    check("t1_wr_r1_ready", r1_ready, 0);
    @(negedge clk);
    drive(1, 0, 32'h10, 0, 0, 0, 0, 0);
    #1;
    check("t1_rd_ready", r0_ready, 1);
    check("t1_rd_strobe", {dm_read, dm_write}, 2'b10);
    check("t1_no_wr_rsp", r0_rvalid, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("t1_rvalid", {r1_rvalid, r0_rvalid}, 2'b01);
    check("t1_rdata", r0_rdata, 32'hDEADBEEF);
    check("t1_idle_addr", dm_addr, 0);
    @(negedge clk);
    #1;
    check("t1_rvalid_once", r0_rvalid, 0);

    // 2. Back-to-back reads, responses pipelined one cycle behind.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i < 3) drive(1, 0, 32'(i * 4), 0, 0, 0, 0, 0);
      else       drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      check("t2_ready", r0_ready, (i < 3) ? 1 : 0);
      check("t2_rvalid", r0_rvalid, (i > 0) ? 1 : 0);
      if (i > 0) check("t2_rdata", r0_rdata, seed(i - 1));
    end
    @(negedge clk);
    #1;
    check("t2_rvalid_end", r0_rvalid, 0);

    // Lone r1 read: exercises the r1 path and leaves last_grant on r1.
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 0, 32'h8, 0);
    #1;
    check("r1_rd_ready", {r1_ready, r0_ready}, 2'b10);
    check("r1_rd_addr", dm_addr, 32'h8);

    // 3. Contention: both read every cycle.
    p1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
      #1;
      g0 = RR ? (i % 2 == 0) : 1'b1;
      check("t3_r0_ready", r0_ready, g0);
      check("t3_r1_ready", r1_ready, !g0);
      check("t3_addr", dm_addr, g0 ? 32'h0 : 32'h4);
      check("t3_rvalid", {r1_rvalid, r0_rvalid}, p1 ? 2'b10 : 2'b01);
      check("t3_rdata", p1 ? r1_rdata : r0_rdata, (i == 0) ? seed(2) : (p1 ? seed(1) : seed(0)));
      p1 = !g0;
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("t3_last_rvalid", {r1_rvalid, r0_rvalid}, RR ? 2'b10 : 2'b01);
    check("t3_last_rdata", RR ? r1_rdata : r0_rdata, RR ? seed(1) : seed(0));

    // 4. r0 read and r1 write to 0x20 in the same cycle; r0 wins in both builds.
    @(negedge clk);
    drive(1, 0, 32'h20, 0, 1, 1, 32'h20, 32'h12345678);
    #1;
    check("t4_c1_ready", {r1_ready, r0_ready}, 2'b01);
    check("t4_c1_strobe", {dm_read, dm_write}, 2'b10);
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 1, 32'h20, 32'h12345678);
    #1;
    check("t4_c2_ready", {r1_ready, r0_ready}, 2'b10);
    check("t4_c2_strobe", {dm_read, dm_write}, 2'b01);
    check("t4_c2_rvalid", {r1_rvalid, r0_rvalid}, 2'b01);
    check("t4_old_data", r0_rdata, seed(8));
    @(negedge clk);
    drive(1, 0, 32'h20, 0, 0, 0, 0, 0);
    #1;
    check("t4_c3_ready", r0_ready, 1);
    check("t4_c3_no_wr_rsp", {r1_rvalid, r0_rvalid}, 2'b00);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("t4_c4_rvalid", {r1_rvalid, r0_rvalid}, 2'b01);
    check("t4_new_data", r0_rdata, 32'h12345678);

    // 5. Reset the cycle after r1's read is accepted; its response is dropped.
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 0, 32'h0, 0);
    #1;
    check("t5_r1_ready", r1_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    drive(1, 0, 32'h4, 0, 1, 0, 32'h8, 0);
    #1;
    check("t5_rst_rvalid", {r1_rvalid, r0_rvalid}, 2'b00);
    check("t5_rst_strobe", {dm_read, dm_write}, 2'b00);
    check("t5_rst_ready", {r1_ready, r0_ready}, 2'b00);
    check("t5_rst_rdata", r1_rdata, 0);
    check("t5_rst_addr", dm_addr, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t5_first_grant", {r1_ready, r0_ready}, 2'b01);
    check("t5_dropped", {r1_rvalid, r0_rvalid}, 2'b00);
    @(negedge clk);
    #1;
    check("t5_second_grant", {r1_ready, r0_ready}, RR ? 2'b10 : 2'b01);
    check("t5_rvalid", r0_rvalid, 1);
    check("t5_rdata", r0_rdata, seed(1));
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("t5_rvalid2", {r1_rvalid, r0_rvalid}, RR ? 2'b10 : 2'b01);
    check("t5_rdata2", RR ? r1_rdata : r0_rdata, RR ? seed(2) : seed(1));
    @(negedge clk);
    #3;
    done = 1'b1;

    // Exactly one accepted read (r1's, cut by reset) never received its response.
    check("rsp_count", rv_cnt, rd_cnt - 1);
    check("rsp_count_nonzero", {31'd0, rd_cnt > 10}, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
